// File: rtl/serial_uart.sv
// serial_uart: full-duplex 8N1 UART with independent transmitter and receiver.
// Bit period DIV = CLOCK_RATE / BAUD clock cycles. Synchronous active-high reset.
module serial_uart #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD       = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic       serial_out,
  input  logic [7:0] as_data_i,
  input  logic       as_dstrb_i,
  output logic       as_busy_o,
  output logic [7:0] as_data_o,
  output logic       as_dstrb_o
);

  localparam int DIV   = CLOCK_RATE / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------------------------------------------------------- transmitter
  tx_state_t        r_tx_state;
  tx_state_t        w_tx_next;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit_cnt;
  logic [7:0]       r_tx_shift;
  logic             w_tx_tick;

  assign w_tx_tick = (r_tx_cnt == DIV_LAST);

  // TX state register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  // TX next-state: a strobe in IDLE starts a frame; each bit lasts DIV cycles
  // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE:  if (as_dstrb_i)                        w_tx_next = TX_START;
      TX_START: if (w_tx_tick)                         w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit_cnt == 3'd7) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick)                         w_tx_next = TX_IDLE;
      default:                                         w_tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: line level and busy decoded from the state
  always_comb begin
    serial_out = 1'b1;
    as_busy_o  = (r_tx_state != TX_IDLE);
    unique case (r_tx_state)
      TX_START: serial_out = 1'b0;
      TX_DATA:  serial_out = r_tx_shift[0];
      default:  serial_out = 1'b1;
    endcase
  end

  // TX datapath: baud counter, bit counter, shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_cnt     <= '0;
      r_tx_bit_cnt <= '0;
      r_tx_shift   <= '0;
    end else if (r_tx_state == TX_IDLE) begin
      r_tx_cnt     <= '0;
      r_tx_bit_cnt <= '0;
      if (as_dstrb_i) r_tx_shift <= as_data_i;
    end else begin
      r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + CNT_ONE;
      if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit_cnt <= r_tx_bit_cnt + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------- receiver
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_next;
  logic             r_rx_sync1;
  logic             r_rx_sync2;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit_cnt;
  logic [7:0]       r_rx_shift;
  logic             w_rx_bit;
  logic             w_rx_fall;
  logic             w_rx_tick;
  logic             w_rx_half;
  logic             w_rx_sample;
  logic             w_rx_accept;

  assign w_rx_bit  = r_rx_sync2;
  assign w_rx_fall = r_rx_prev & ~r_rx_sync2;
  assign w_rx_tick = (r_rx_cnt == DIV_LAST);
  assign w_rx_half = (r_rx_cnt == HALF_LAST);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= serial_in;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (reset) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  // RX next-state: confirm start at mid-bit, 8 data bits, then check stop
  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE:      if (w_rx_fall) w_rx_next = RX_START;
      RX_START:     if (w_rx_half) w_rx_next = w_rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_rx_tick && r_rx_bit_cnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:      if (w_rx_tick) w_rx_next = w_rx_bit ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (w_rx_bit)  w_rx_next = RX_IDLE;
      default:                     w_rx_next = RX_IDLE;
    endcase
  end

  // RX control decodes: data-bit sample strobe and good-stop acceptance
  always_comb begin
    w_rx_sample = (r_rx_state == RX_DATA) && w_rx_tick;
    w_rx_accept = (r_rx_state == RX_STOP) && w_rx_tick && w_rx_bit;
  end

  // RX datapath: counters, shift register, output byte and strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt     <= '0;
      r_rx_bit_cnt <= '0;
      r_rx_shift   <= '0;
      as_data_o    <= '0;
      as_dstrb_o   <= 1'b0;
    end else begin
      as_dstrb_o <= w_rx_accept;
      if (w_rx_accept) as_data_o <= r_rx_shift;
      unique case (r_rx_state)
        RX_START:        r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + CNT_ONE;
        RX_DATA, RX_STOP: r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + CNT_ONE;
        default: begin
          r_rx_cnt     <= '0;
          r_rx_bit_cnt <= '0;
        end
      endcase
      if (w_rx_sample) begin
        r_rx_shift   <= {w_rx_bit, r_rx_shift[7:1]};
        r_rx_bit_cnt <= r_rx_bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_uart.sv
// tb_serial_uart: scoreboard bench for serial_uart at DIV = 16 (loopback and direct RX drive).
module tb_serial_uart;

  localparam int DIV = 16;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       tb_loop    = 1'b1;
  logic       tb_rx_line = 1'b1;
  logic       serial_in;
  logic       serial_out;
  logic [7:0] as_data_i  = 8'h00;
  logic       as_dstrb_i = 1'b0;
  logic       as_busy_o;
  logic [7:0] as_data_o;
  logic       as_dstrb_o;

  int         checks   = 0;
  int         errors   = 0;
  int         rx_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;

  assign serial_in = tb_loop ? serial_out : tb_rx_line;

  serial_uart #(.CLOCK_RATE(16), .BAUD(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .as_data_i  (as_data_i),
    .as_dstrb_i (as_dstrb_i),
    .as_busy_o  (as_busy_o),
    .as_data_o  (as_data_o),
    .as_dstrb_o (as_dstrb_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every receive pulse pops one expected byte from the scoreboard
  always @(negedge clk) begin
    if (!reset && as_dstrb_o) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%02h expected=no_pulse", as_data_o);
      end else begin
        last_exp = exp_q.pop_front();
        check("rx_byte", as_data_o, last_exp);
      end
    end
  end

  // Issue a transmit request from a negedge; returns #1 after the edge that sets busy
  task automatic start_tx(input logic [7:0] b, input bit expect_rx);
    int t;
    t = 0;
    while (as_busy_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    as_data_i  = b;
    as_dstrb_i = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!as_busy_o && t < 4);
    as_dstrb_i = 1'b0;
    check("tx_busy_latency", t, 1);
    check("tx_busy_rise", as_busy_o, 1'b1);
    if (expect_rx) exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("rx_drain_left", exp_q.size(), 0);
  endtask

  // Drive one 8N1 frame directly onto serial_in, starting at a negedge
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      tb_rx_line = bits[k];
      repeat (DIV) @(negedge clk);
    end
    tb_rx_line = 1'b1;
  endtask

  initial begin
    int         busy_cnt;
    int         low_cnt;
    int         rx_before;
    int         sent;
    logic       prev_busy;
    logic [7:0] cnt;
    logic [7:0] keep;
    logic [9:0] exp_frame;
    logic [9:0] line_bits;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_serial_out", serial_out, 1'b1);
    check("rst_busy", as_busy_o, 1'b0);
    check("rst_dstrb", as_dstrb_o, 1'b0);
    check("rst_data", as_data_o, 8'h00);
    reset = 1'b0;

    // Idle 100 cycles
    busy_cnt = 0;
    low_cnt  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (as_busy_o) busy_cnt++;
      if (!serial_out) low_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_line_low_cycles", low_cnt, 0);
    check("idle_rx_pulses", rx_count, 0);

    // Single frame 8'h01: line pattern and busy length
    @(negedge clk);
    start_tx(8'h01, 1'b1);
    exp_frame = {1'b1, 8'h01, 1'b0};
    line_bits = '0;
    busy_cnt  = 0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (as_busy_o) busy_cnt++;
      if ((i % DIV) == DIV / 2 && (i / DIV) < 10) line_bits[i / DIV] = serial_out;
    end
    check("frame01_busy_cycles", busy_cnt, 160);
    for (int k = 0; k < 10; k++) check($sformatf("frame01_bit%0d", k), line_bits[k], exp_frame[k]);
    wait_drain(200);
    check("frame01_data_out", as_data_o, 8'h01);

    // Strobe during busy is ignored
    @(negedge clk);
    rx_before = rx_count;
    start_tx(8'h55, 1'b1);
    repeat (50) @(negedge clk);
    as_data_i  = 8'hAA;
    as_dstrb_i = 1'b1;
    repeat (3) @(negedge clk);
    check("ignore_busy_held", as_busy_o, 1'b1);
    as_dstrb_i = 1'b0;
    wait_drain(300);
    repeat (200) @(negedge clk);
    check("ignore_rx_count", rx_count - rx_before, 1);
    check("ignore_data_out", as_data_o, 8'h55);
    check("ignore_idle", as_busy_o, 1'b0);

    // Back-to-back counter stream with strobe held high (level-sensitive restart)
    @(negedge clk);
    rx_before  = rx_count;
    sent       = 0;
    cnt        = 8'd1;
    prev_busy  = as_busy_o;
    as_data_i  = cnt;
    as_dstrb_i = 1'b1;
    for (int c = 0; c < 32000; c++) begin
      @(posedge clk);
      #1;
      if (as_busy_o && !prev_busy) begin
        exp_q.push_back(cnt);
        cnt++;
        sent++;
        as_data_i = cnt;
      end
      prev_busy = as_busy_o;
    end
    as_dstrb_i = 1'b0;
    check("stream_frames_sent", sent, 199);
    check("stream_backlog_le1", (exp_q.size() <= 1), 1'b1);
    wait_drain(400);
    check("stream_rx_count", rx_count - rx_before, sent);

    // Direct drive: framing error then a good frame
    @(negedge clk);
    tb_rx_line = 1'b1;
    tb_loop    = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    keep      = last_exp;
    rx_before = rx_count;
    drive_frame(8'hC3, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    check("ferr_no_pulse", rx_count - rx_before, 0);
    check("ferr_data_hold", as_data_o, keep);
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    wait_drain(100);
    check("ferr_recover_data", as_data_o, 8'h3C);

    // Start-bit glitch of 4 cycles, then a good frame still received
    repeat (2 * DIV) @(negedge clk);
    rx_before  = rx_count;
    tb_rx_line = 1'b0;
    repeat (4) @(negedge clk);
    tb_rx_line = 1'b1;
    repeat (20 * DIV) @(negedge clk);
    check("glitch_no_pulse", rx_count - rx_before, 0);
    exp_q.push_back(8'hA5);
    drive_frame(8'hA5, 1'b1);
    wait_drain(100);

    // Reset during data bit 4 of a loopback frame
    repeat (2 * DIV) @(negedge clk);
    tb_loop = 1'b1;
    repeat (2) @(negedge clk);
    rx_before = rx_count;
    start_tx(8'h0F, 1'b0);
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    check("midrst_busy_before", as_busy_o, 1'b1);
    reset      = 1'b1;
    as_data_i  = 8'hFF;
    as_dstrb_i = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_serial_out", serial_out, 1'b1);
    check("midrst_busy", as_busy_o, 1'b0);
    check("midrst_dstrb", as_dstrb_o, 1'b0);
    check("midrst_data", as_data_o, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_strobe_ignored", as_busy_o, 1'b0);
    reset      = 1'b0;
    as_dstrb_i = 1'b0;
    low_cnt    = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!serial_out) low_cnt++;
    end
    check("midrst_line_high", low_cnt, 0);
    check("midrst_no_partial", rx_count - rx_before, 0);
    check("midrst_busy_after", as_busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
